mmu_sfr_read_responder: RTL and testbench
=========================================

MMU_SFR_READ_RESPONDER -- requirements
Module: mmu_sfr_read_responder

Interface
REQ-001 Parameter SFR_BASE, default 8'h20: index of the first implemented SFR.
REQ-002 Parameter NUM_SFR, default 8: number of implemented SFRs; valid range 2..16.
REQ-003 Parameter MMU_ID, default 32'h4B4D_0001: constant value of SFR[0].
REQ-004 Port clock  in  1: single clock; all state updates on the rising edge.
REQ-005 Port reset  in  1: asynchronous, active-low reset.
REQ-006 Port f_sfr_read_en_i_m  in  1: M-stage SFR read request.
REQ-007 Port f_sfr_read_idx_i_m  in  8: M-stage SFR index.
REQ-008 Port rr_stall_i_m  in  1: pipeline stall; freezes acceptance and the result stage.
REQ-009 Port rr_result_o  out  32: read data, registered.
REQ-010 Port rr_result_valid_o  out  1: rr_result_o carries an accepted read.
REQ-011 Port rr_bad_idx_o  out  1: accepted read targeted an unimplemented index.
REQ-012 Port sfr_wr_en_i  in  1: SFR write strobe.
REQ-013 Port sfr_wr_idx_i  in  8: SFR write index.
REQ-014 Port sfr_wr_data_i  in  32: SFR write data.
REQ-015 Port bad_idx_count_o  out  8: count of bad-index reads.

Function
REQ-016 Storage: SFR[k] for k = 0..NUM_SFR-1 maps to index SFR_BASE+k; all other indices are unimplemented.
- SFR[0]: read-only, always MMU_ID.
- SFR[NUM_SFR-1]: read-only free-running 32-bit cycle counter; increments every cycle, wraps from FFFF_FFFF to 0; unaffected by stall.
- All other SFRs: read/write.
REQ-017 Read acceptance: a read is accepted on an edge where f_sfr_read_en_i_m=1 and rr_stall_i_m=0.
REQ-018 Latency: one cycle. After the accepting edge, rr_result_valid_o=1 and rr_result_o = SFR data as sampled at that edge.
REQ-019 Stall hold: while rr_stall_i_m=1, rr_result_o, rr_result_valid_o and rr_bad_idx_o keep their values, and no request is accepted.
REQ-020 Idle: on an edge with rr_stall_i_m=0 and f_sfr_read_en_i_m=0, the block loads rr_result_valid_o=0, rr_result_o=0 and rr_bad_idx_o=0.
REQ-021 Back-to-back reads: unstalled reads on consecutive cycles produce one result per cycle, in order.
REQ-022 Bad index: an accepted read to an unimplemented index returns rr_result_o=0, rr_result_valid_o=1 and rr_bad_idx_o=1.
- bad_idx_count_o increments by 1 on that edge and saturates at 8'hFF.
REQ-023 Writes:
- Occur on any edge with sfr_wr_en_i=1, independent of rr_stall_i_m.
- Writes to read-only or unimplemented indices are ignored and do not count as bad.
REQ-024 Same-edge read/write to the same read/write SFR: the accepted read returns sfr_wr_data_i (write-through forwarding).
REQ-025 Counter read: returns the counter value before that edge's increment.

Reset
REQ-026 While reset=0, all outputs and state are forced asynchronously to:
- rr_result_o=0, rr_result_valid_o=0, rr_bad_idx_o=0, bad_idx_count_o=0
- all read/write SFRs = 0
- cycle counter = 0
REQ-027 Reset assertion mid-read or mid-stall discards the pending result.
REQ-028 The first acceptance occurs on the first rising edge after reset deasserts.

Verification
REQ-029 Reset, then read idx 8'h20 with no stall -> next cycle rr_result_o=32'h4B4D_0001, valid=1, bad=0.
REQ-030 Write 32'hDEAD_BEEF to 8'h22 and read 8'h22 on the same edge -> result 32'hDEAD_BEEF; a write to 8'h20 followed by a read of 8'h20 -> still MMU_ID.
REQ-031 Read 8'h23 accepted, then rr_stall_i_m=1 for 3 cycles while en=1 with idx 8'h24 -> result of 8'h23 held for 3 cycles; 8'h24 is accepted only on the first unstalled edge.
REQ-032 Read 8'h05 300 times -> each result is 0 with bad=1; bad_idx_count_o stops at 8'hFF.
REQ-033 Read counter (8'h27) on two consecutive edges -> second result = first result + 1; forcing the counter to FFFF_FFFF shows wrap to 0.
REQ-034 Assert reset for one cycle while valid=1 and stalled -> outputs become 0 immediately; SFR 8'h21 reads back 0 afterward.

Source files
------------

// File: rtl/mmu_sfr_read_responder.sv
// SFR read responder for the MMU. It serves M-stage SFR reads with one cycle of latency.
// It also holds the read/write SFR bank, the ID register, a free-running cycle counter and the bad-index counter.
module mmu_sfr_read_responder #(
    parameter logic [7:0]  SFR_BASE = 8'h20,
    parameter int          NUM_SFR  = 8,
    parameter logic [31:0] MMU_ID   = 32'h4B4D_0001
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        f_sfr_read_en_i_m,
    input  logic [7:0]  f_sfr_read_idx_i_m,
    input  logic        rr_stall_i_m,
    output logic [31:0] rr_result_o,
    output logic        rr_result_valid_o,
    output logic        rr_bad_idx_o,
    input  logic        sfr_wr_en_i,
    input  logic [7:0]  sfr_wr_idx_i,
    input  logic [31:0] sfr_wr_data_i,
    output logic [7:0]  bad_idx_count_o
);

    localparam logic [7:0] LAST_OFF = 8'(NUM_SFR - 1);

    logic [31:0] cycle_cnt;
    logic [31:0] sfr_view [NUM_SFR];
    logic [8:0]  rd_off;
    logic [8:0]  wr_off;
    logic        rd_hit;
    logic        wr_hit;
    logic        rd_is_rw;
    logic        wr_fwd;
    logic        accept;
    logic [31:0] rd_data;

    // A 9-bit subtraction makes indices below SFR_BASE show up as a borrow in bit 8.
    assign rd_off   = {1'b0, f_sfr_read_idx_i_m} - {1'b0, SFR_BASE};
    assign wr_off   = {1'b0, sfr_wr_idx_i} - {1'b0, SFR_BASE};
    assign rd_hit   = !rd_off[8] && (rd_off[7:0] < 8'(NUM_SFR));
    assign wr_hit   = !wr_off[8] && (wr_off[7:0] < 8'(NUM_SFR));
    assign rd_is_rw = rd_hit && (rd_off[7:0] != 8'd0) && (rd_off[7:0] != LAST_OFF);
    assign wr_fwd   = sfr_wr_en_i && rd_is_rw && (sfr_wr_idx_i == f_sfr_read_idx_i_m);
    assign accept   = f_sfr_read_en_i_m && !rr_stall_i_m;

    for (genvar k = 0; k < NUM_SFR; k++) begin : g_sfr
        if (k == 0) begin : g_id
            assign sfr_view[k] = MMU_ID;
        end else if (k == NUM_SFR - 1) begin : g_cnt
            assign sfr_view[k] = cycle_cnt;
        end else begin : g_rw
            logic [31:0] q;
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    q <= '0;
                end else if (sfr_wr_en_i && wr_hit && (wr_off[7:0] == 8'(k))) begin
                    q <= sfr_wr_data_i;
                end
            end
            assign sfr_view[k] = q;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_SFR; k++) begin
            if (rd_hit && (rd_off[7:0] == 8'(k))) begin
                rd_data = sfr_view[k];
            end
        end
        // A same-edge write wins, so the reader never sees stale data.
        if (wr_fwd) begin
            rd_data = sfr_wr_data_i;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_result_o       <= '0;
            rr_result_valid_o <= 1'b0;
            rr_bad_idx_o      <= 1'b0;
            bad_idx_count_o   <= '0;
        end else if (!rr_stall_i_m) begin
            if (accept) begin
                rr_result_valid_o <= 1'b1;
                rr_result_o       <= rd_hit ? rd_data : 32'd0;
                rr_bad_idx_o      <= !rd_hit;
                if (!rd_hit && (bad_idx_count_o != 8'hFF)) begin
                    bad_idx_count_o <= bad_idx_count_o + 8'd1;
                end
            end else begin
                rr_result_valid_o <= 1'b0;
                rr_result_o       <= '0;
                rr_bad_idx_o      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mmu_sfr_read_responder.sv
// Bench for mmu_sfr_read_responder. Stimulus pushes the expected read results into a queue.
// A monitor pops that queue and compares one cycle after each accepted read.
module tb_mmu_sfr_read_responder;

    localparam logic [31:0] ID = 32'h4B4D_0001;

    typedef struct {
        logic [7:0]  idx;
        logic [31:0] res;
        logic        bad;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  idx = 8'h00;
    logic        stall = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_idx = 8'h00;
    logic [31:0] wr_data = 32'h0;
    logic [31:0] result;
    logic        valid;
    logic        bad;
    logic [7:0]  bad_cnt;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    logic acc_pending = 1'b0;
    logic [31:0] model_cnt;

    mmu_sfr_read_responder dut (
        .clock              (clock),
        .reset              (reset),
        .f_sfr_read_en_i_m  (en),
        .f_sfr_read_idx_i_m (idx),
        .rr_stall_i_m       (stall),
        .rr_result_o        (result),
        .rr_result_valid_o  (valid),
        .rr_bad_idx_o       (bad),
        .sfr_wr_en_i        (wr_en),
        .sfr_wr_idx_i       (wr_idx),
        .sfr_wr_data_i      (wr_data),
        .bad_idx_count_o    (bad_cnt)
    );

    always #5 clock = ~clock;

    // Reference cycle counter: the number of rising edges since reset was released.
    always @(posedge clock or negedge reset) begin
        if (!reset) model_cnt <= 32'h0;
        else        model_cnt <= model_cnt + 32'h1;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check32({tag, " result"}, result, 32'h0);
        check32({tag, " valid"}, {31'b0, valid}, 32'h0);
        check32({tag, " bad"}, {31'b0, bad}, 32'h0);
        check32({tag, " bad_cnt"}, {24'b0, bad_cnt}, 32'h0);
    endtask

    always @(posedge clock) acc_pending = reset && en && !stall;

    always @(negedge reset) begin
        acc_pending = 1'b0;
        exp_q.delete();
    end

    always @(negedge clock) begin
        if (acc_pending) begin
            exp_t e;
            acc_pending = 1'b0;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard: result %h with nothing expected", result);
            end else begin
                e = exp_q.pop_front();
                if (!(valid === 1'b1 && result === e.res && bad === e.bad)) begin
                    fails++;
                    $display("FAIL read idx %h: got valid=%b data=%h bad=%b expected valid=1 data=%h bad=%b",
                             e.idx, valid, result, bad, e.res, e.bad);
                end
            end
        end
    end

    task automatic rd(input logic [7:0] i, input logic [31:0] r, input logic b);
        exp_t e;
        e.idx = i;
        e.res = r;
        e.bad = b;
        en    = 1'b1;
        idx   = i;
        stall = 1'b0;
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    task automatic idle();
        en    = 1'b0;
        stall = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        #12;
        check_zero_outputs("reset");
        @(negedge clock);
        reset = 1'b1;

        rd(8'h20, ID, 1'b0);
        idle();
        check32("idle result", result, 32'h0);
        check32("idle valid", {31'b0, valid}, 32'h0);
        check32("idle bad", {31'b0, bad}, 32'h0);

        wr_en = 1'b1; wr_idx = 8'h22; wr_data = 32'hDEAD_BEEF;
        rd(8'h22, 32'hDEAD_BEEF, 1'b0);
        wr_en = 1'b0;
        rd(8'h22, 32'hDEAD_BEEF, 1'b0);
        wr_en = 1'b1; wr_idx = 8'h20; wr_data = 32'h1234_5678;
        rd(8'h20, ID, 1'b0);
        wr_en = 1'b0;
        rd(8'h20, ID, 1'b0);
        wr_en = 1'b1; wr_idx = 8'h05; wr_data = 32'hAAAA_5555;
        rd(8'h21, 32'h0, 1'b0);
        wr_en = 1'b0;
        check32("bad_cnt after ignored writes", {24'b0, bad_cnt}, 32'h0);

        wr_en = 1'b1; wr_idx = 8'h21; wr_data = 32'h1111_1111;
        idle();
        wr_idx = 8'h23; wr_data = 32'h3333_3333;
        idle();
        wr_en = 1'b0;
        rd(8'h21, 32'h1111_1111, 1'b0);
        rd(8'h23, 32'h3333_3333, 1'b0);
        rd(8'h26, 32'h0, 1'b0);
        rd(8'h22, 32'hDEAD_BEEF, 1'b0);

        rd(8'h23, 32'h3333_3333, 1'b0);
        stall = 1'b1; en = 1'b1; idx = 8'h24;
        wr_en = 1'b1; wr_idx = 8'h24; wr_data = 32'h4444_4444;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            wr_en = 1'b0;
            check32("stall hold result", result, 32'h3333_3333);
            check32("stall hold valid", {31'b0, valid}, 32'h1);
        end
        rd(8'h24, 32'h4444_4444, 1'b0);
        idle();

        rd(8'h1F, 32'h0, 1'b1);
        rd(8'h28, 32'h0, 1'b1);
        idle();
        check32("bad_cnt after 2", {24'b0, bad_cnt}, 32'd2);
        for (int i = 0; i < 300; i++) rd(8'h05, 32'h0, 1'b1);
        idle();
        check32("bad_cnt saturated", {24'b0, bad_cnt}, 32'h0000_00FF);

        rd(8'h27, model_cnt, 1'b0);
        rd(8'h27, model_cnt, 1'b0);
        idle();
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt;
        rd(8'h27, 32'hFFFF_FFFF, 1'b0);
        rd(8'h27, 32'h0, 1'b0);
        idle();

        wr_en = 1'b1; wr_idx = 8'h21; wr_data = 32'h5555_5555;
        rd(8'h21, 32'h5555_5555, 1'b0);
        wr_en = 1'b0;
        stall = 1'b1; en = 1'b1; idx = 8'h21;
        @(posedge clock);
        #2;
        check32("pre-reset held valid", {31'b0, valid}, 32'h1);
        reset = 1'b0;
        #1;
        check_zero_outputs("mid-stall reset");
        @(negedge clock);
        reset = 1'b1;
        rd(8'h21, 32'h0, 1'b0);
        rd(8'h27, model_cnt, 1'b0);
        rd(8'h22, 32'h0, 1'b0);
        idle();
        idle();

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL leftover expectations: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
